// File: rtl/draw_sequencer_if.sv
// Plot-path bundle between the frame sequencer, the draw engines, the level
// loader, collision logic and the vga_adapter. The sequencer drives the
// master side; everything around it sits on the slave side.
interface draw_sequencer_if #(
    parameter int NUM_CH   = 4,
    parameter int COORD_W  = 10,
    parameter int COLOUR_W = 3
);
    logic                         frame_tick;
    logic [NUM_CH-1:0]            ch_mask;
    logic [NUM_CH-1:0]            erase_mask;
    logic [NUM_CH-1:0]            ch_go;
    logic [NUM_CH-1:0]            ch_done;
    logic [NUM_CH*COORD_W-1:0]    ch_x;
    logic [NUM_CH*COORD_W-1:0]    ch_y;
    logic [NUM_CH*COLOUR_W-1:0]   ch_colour;
    logic [NUM_CH-1:0]            ch_we;
    logic                         load_active;
    logic [COORD_W-1:0]           load_x;
    logic [COORD_W-1:0]           load_y;
    logic [COLOUR_W-1:0]          load_colour;
    logic                         load_we;
    logic                         logic_go;
    logic                         logic_done;
    logic                         inc_enable;
    logic [COORD_W-1:0]           x;
    logic [COORD_W-1:0]           y;
    logic [COLOUR_W-1:0]          colour;
    logic                         plot;
    logic                         erasing;
    logic                         busy;
    logic [NUM_CH-1:0]            timeout_flags;
    logic                         overrun;

    modport master (
        input  frame_tick, ch_mask, erase_mask, ch_done, ch_x, ch_y, ch_colour, ch_we,
               load_active, load_x, load_y, load_colour, load_we, logic_done,
        output ch_go, logic_go, inc_enable, x, y, colour, plot, erasing, busy,
               timeout_flags, overrun
    );

    modport slave (
        output frame_tick, ch_mask, erase_mask, ch_done, ch_x, ch_y, ch_colour, ch_we,
               load_active, load_x, load_y, load_colour, load_we, logic_done,
        input  ch_go, logic_go, inc_enable, x, y, colour, plot, erasing, busy,
               timeout_flags, overrun
    );
endinterface

// File: rtl/draw_sequencer.sv
// Frame sequencer and pixel multiplexer for the VGA plot path. Each frame:
// erase pass over the enabled channels, collision-logic handshake plus a
// position-increment pulse, then the draw pass. Every wait is bounded by
// TIMEOUT so a stuck engine cannot hang the frame loop.
module draw_sequencer #(
    parameter int                    NUM_CH    = 4,
    parameter int                    COORD_W   = 10,
    parameter int                    COLOUR_W  = 3,
    parameter int unsigned           TIMEOUT   = 20'd4096,
    parameter logic [COLOUR_W-1:0]   BG_COLOUR = '0
) (
    input  logic              clk,
    input  logic              reset,
    draw_sequencer_if.master  bus
);

    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE, E_GO, E_WAIT, L_GO, L_WAIT, INC, D_GO, D_WAIT
    } state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [NUM_CH-1:0] flags_q, flags_d;
    logic              overrun_q, overrun_d;

    logic [IDX_W:0]    first_erase, next_erase, first_draw, next_draw, next_sel;
    logic              done_act, tmo_hit;

    // Lowest set bit of mask at or above position from; MSB flags "found".
    function automatic logic [IDX_W:0] pick_ch(input logic [NUM_CH-1:0] mask, input int from);
        logic [IDX_W:0] r;
        r = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask[i] && (i >= from)) r = {1'b1, IDX_W'(i)};
        end
        return r;
    endfunction

    // Masks are looked at live at every selection point, never latched per frame.
    assign first_erase = pick_ch(bus.ch_mask & bus.erase_mask, 0);
    assign next_erase  = pick_ch(bus.ch_mask & bus.erase_mask, int'(idx_q) + 1);
    assign first_draw  = pick_ch(bus.ch_mask, 0);
    assign next_draw   = pick_ch(bus.ch_mask, int'(idx_q) + 1);
    assign next_sel    = (state_q == E_WAIT) ? next_erase : next_draw;
    assign done_act    = bus.ch_done[idx_q];
    assign tmo_hit     = (cnt_q == CNT_LAST);

    // State, channel index, wait counter and sticky status registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            cnt_q     <= '0;
            flags_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            flags_q   <= flags_d;
            overrun_q <= overrun_d;
        end
    end

    // Next-state logic; the whole FSM and its counter hold while the loader owns the path.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        flags_d   = flags_q;
        overrun_d = overrun_q | (bus.frame_tick && (state_q != IDLE));

        if (!bus.load_active) begin
            case (state_q)
                IDLE: begin
                    if (bus.frame_tick) begin
                        if (first_erase[IDX_W]) begin
                            idx_d   = first_erase[IDX_W-1:0];
                            state_d = E_GO;
                        end else begin
                            state_d = L_GO;
                        end
                    end
                end
                E_GO, D_GO: begin
                    cnt_d   = '0;
                    state_d = (state_q == E_GO) ? E_WAIT : D_WAIT;
                end
                E_WAIT, D_WAIT: begin
                    if (done_act || tmo_hit) begin
                        // A done arriving on the timeout cycle still counts as a clean finish.
                        if (!done_act) flags_d[idx_q] = 1'b1;
                        if (next_sel[IDX_W]) begin
                            idx_d   = next_sel[IDX_W-1:0];
                            state_d = (state_q == E_WAIT) ? E_GO : D_GO;
                        end else begin
                            state_d = (state_q == E_WAIT) ? L_GO : IDLE;
                        end
                    end else if (cnt_q != '1) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                L_GO: begin
                    cnt_d   = '0;
                    state_d = L_WAIT;
                end
                L_WAIT: begin
                    if (bus.logic_done || tmo_hit) begin
                        state_d = INC;
                    end else if (cnt_q != '1) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                INC: begin
                    if (first_draw[IDX_W]) begin
                        idx_d   = first_draw[IDX_W-1:0];
                        state_d = D_GO;
                    end else begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Pulse outputs, status and the combinational pixel mux toward vga_adapter.
    always_comb begin
        bus.ch_go         = '0;
        bus.logic_go      = 1'b0;
        bus.inc_enable    = 1'b0;
        bus.erasing       = (state_q == E_GO) || (state_q == E_WAIT);
        bus.busy          = (state_q != IDLE);
        bus.timeout_flags = flags_q;
        bus.overrun       = overrun_q;
        bus.x             = bus.ch_x[idx_q*COORD_W +: COORD_W];
        bus.y             = bus.ch_y[idx_q*COORD_W +: COORD_W];
        bus.colour        = bus.ch_colour[idx_q*COLOUR_W +: COLOUR_W];
        bus.plot          = 1'b0;

        if (!bus.load_active) begin
            if ((state_q == E_GO) || (state_q == D_GO)) bus.ch_go[idx_q] = 1'b1;
            bus.logic_go   = (state_q == L_GO);
            bus.inc_enable = (state_q == INC);
        end

        if (bus.load_active) begin
            bus.x      = bus.load_x;
            bus.y      = bus.load_y;
            bus.colour = bus.load_colour;
            bus.plot   = bus.load_we;
        end else if ((state_q == E_GO) || (state_q == E_WAIT) ||
                     (state_q == D_GO) || (state_q == D_WAIT)) begin
            bus.plot = bus.ch_we[idx_q];
            if (bus.erasing) bus.colour = BG_COLOUR;
        end
    end

endmodule

// File: tb/tb_draw_sequencer.sv
// Self-checking bench for draw_sequencer: directed scenarios plus randomized
// frames checked cycle by cycle against a schedule built from the frame rules.
module tb_draw_sequencer;
    localparam int N   = 4;
    localparam int CW  = 10;
    localparam int KW  = 3;
    localparam int TMO = 16;

    localparam int K_EGO = 0, K_EWAIT = 1, K_LGO = 2, K_LWAIT = 3, K_INC = 4, K_DGO = 5, K_DWAIT = 6;

    typedef struct { int kind; int ch; } ent_t;

    logic clk;
    logic reset;
    draw_sequencer_if #(.NUM_CH(N), .COORD_W(CW), .COLOUR_W(KW)) bus();

    draw_sequencer #(
        .NUM_CH(N), .COORD_W(CW), .COLOUR_W(KW), .TIMEOUT(TMO), .BG_COLOUR(3'b000)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int dly[N];
    int cd[N];
    int ldly;
    int lcd;
    bit noise;
    bit rand_pix;
    logic [N-1:0] exp_flags;
    logic         exp_overrun;
    ent_t sched[$];

    // One clock: set loader ownership, refresh pixel inputs, act as the draw engines.
    task automatic step(input bit hold);
        logic [N-1:0] dn;
        logic ldn;
        @(negedge clk);
        bus.load_active = hold;
        if (rand_pix) begin
            bus.ch_x        = 40'({$urandom(), $urandom()});
            bus.ch_y        = 40'({$urandom(), $urandom()});
            bus.ch_colour   = 12'($urandom());
            bus.ch_we       = 4'($urandom());
            bus.load_x      = 10'($urandom());
            bus.load_y      = 10'($urandom());
            bus.load_colour = 3'($urandom());
            bus.load_we     = 1'($urandom());
        end
        #1;
        dn = '0;
        for (int i = 0; i < N; i++) begin
            if (!hold && cd[i] > 0) begin
                cd[i]--;
                if (cd[i] == 0) dn[i] = 1'b1;
            end
            if (bus.ch_go[i]) begin
                cd[i] = dly[i];
                if (noise && $urandom_range(0, 1) == 1) dn[i] = 1'b1;
            end
            if (noise && !bus.ch_mask[i] && $urandom_range(0, 3) == 0) dn[i] = 1'b1;
        end
        bus.ch_done = dn;
        ldn = 1'b0;
        if (!hold && lcd > 0) begin
            lcd--;
            if (lcd == 0) ldn = 1'b1;
        end
        if (bus.logic_go) lcd = ldly;
        bus.logic_done = ldn;
        #1;
    endtask

    task automatic clear_engines();
        for (int i = 0; i < N; i++) cd[i] = 0;
        lcd = 0;
    endtask

    // Run one frame and compare every cycle against the expected schedule.
    task automatic run_frame(input logic [N-1:0] m, input logic [N-1:0] e, input int tick_at,
                             input int freeze_at, input int freeze_len, input int abort_at,
                             input string tag);
        logic [N-1:0] nf;
        logic [N-1:0] exp_go;
        logic [CW+CW+KW:0] exp_pix, got_pix;
        ent_t en;
        int w;
        bit chk;
        sched.delete();
        nf = '0;
        bus.ch_mask = m;
        bus.erase_mask = e;
        for (int i = 0; i < N; i++) begin
            if (m[i] && e[i]) begin
                sched.push_back('{K_EGO, i});
                w = (dly[i] == 0 || dly[i] > TMO) ? TMO : dly[i];
                if (dly[i] == 0 || dly[i] > TMO) nf[i] = 1'b1;
                for (int j = 0; j < w; j++) sched.push_back('{K_EWAIT, i});
            end
        end
        sched.push_back('{K_LGO, 0});
        w = (ldly == 0 || ldly > TMO) ? TMO : ldly;
        for (int j = 0; j < w; j++) sched.push_back('{K_LWAIT, 0});
        sched.push_back('{K_INC, 0});
        for (int i = 0; i < N; i++) begin
            if (m[i]) begin
                sched.push_back('{K_DGO, i});
                w = (dly[i] == 0 || dly[i] > TMO) ? TMO : dly[i];
                if (dly[i] == 0 || dly[i] > TMO) nf[i] = 1'b1;
                for (int j = 0; j < w; j++) sched.push_back('{K_DWAIT, i});
            end
        end
        if (tick_at >= sched.size()) tick_at = -1;
        if (freeze_at >= sched.size()) freeze_at = -1;

        step(0);
        bus.frame_tick = 1'b1;
        for (int k = 0; k < sched.size(); k++) begin
            if (k == freeze_at) begin
                for (int f = 0; f < freeze_len; f++) begin
                    step(1);
                    bus.frame_tick = 1'b0;
                    total++;
                    if ({bus.busy, bus.ch_go, bus.logic_go, bus.inc_enable} !== {1'b1, 4'b0, 1'b0, 1'b0}) begin
                        bad++;
                        $display("FAIL %s freeze_ctrl k=%0d got=%b want=%b", tag, k,
                                 {bus.busy, bus.ch_go, bus.logic_go, bus.inc_enable}, 7'b1000000);
                    end
                    total++;
                    if ({bus.x, bus.y, bus.colour, bus.plot} !== {bus.load_x, bus.load_y, bus.load_colour, bus.load_we}) begin
                        bad++;
                        $display("FAIL %s freeze_pix k=%0d got=%h want=%h", tag, k,
                                 {bus.x, bus.y, bus.colour, bus.plot},
                                 {bus.load_x, bus.load_y, bus.load_colour, bus.load_we});
                    end
                end
            end
            step(0);
            bus.frame_tick = (k == tick_at);
            if (k == abort_at) begin
                reset = 1'b1;
                step(0);
                reset = 1'b0;
                clear_engines();
                exp_flags = '0;
                exp_overrun = 1'b0;
                total++;
                if ({bus.busy, bus.ch_go, bus.timeout_flags, bus.overrun} !== 10'b0) begin
                    bad++;
                    $display("FAIL %s after_reset got=%b want=%b", tag,
                             {bus.busy, bus.ch_go, bus.timeout_flags, bus.overrun}, 10'b0);
                end
                for (int r = 0; r < 6; r++) begin
                    step(0);
                    total++;
                    if ({bus.busy, bus.ch_go, bus.logic_go, bus.inc_enable} !== 7'b0) begin
                        bad++;
                        $display("FAIL %s post_reset_quiet cyc=%0d got=%b want=%b", tag, r,
                                 {bus.busy, bus.ch_go, bus.logic_go, bus.inc_enable}, 7'b0);
                    end
                end
                return;
            end
            en = sched[k];
            exp_go = (en.kind == K_EGO || en.kind == K_DGO) ? 4'(1 << en.ch) : 4'b0;
            total++;
            if ({bus.ch_go, bus.logic_go, bus.inc_enable, bus.erasing, bus.busy} !==
                {exp_go, en.kind == K_LGO, en.kind == K_INC, en.kind == K_EGO || en.kind == K_EWAIT, 1'b1}) begin
                bad++;
                $display("FAIL %s ctrl k=%0d got=%b want=%b", tag, k,
                         {bus.ch_go, bus.logic_go, bus.inc_enable, bus.erasing, bus.busy},
                         {exp_go, en.kind == K_LGO, en.kind == K_INC, en.kind == K_EGO || en.kind == K_EWAIT, 1'b1});
            end
            chk = (en.kind == K_EGO || en.kind == K_EWAIT || en.kind == K_DGO || en.kind == K_DWAIT);
            if (chk) begin
                exp_pix = {bus.ch_x[en.ch*CW +: CW], bus.ch_y[en.ch*CW +: CW],
                           (en.kind == K_EGO || en.kind == K_EWAIT) ? 3'b000 : bus.ch_colour[en.ch*KW +: KW],
                           bus.ch_we[en.ch]};
                got_pix = {bus.x, bus.y, bus.colour, bus.plot};
            end else begin
                exp_pix = '0;
                got_pix = {{(CW+CW+KW){1'b0}}, bus.plot};
            end
            total++;
            if (got_pix !== exp_pix) begin
                bad++;
                $display("FAIL %s pix k=%0d got=%h want=%h", tag, k, got_pix, exp_pix);
            end
        end
        exp_flags = exp_flags | nf;
        if (tick_at >= 0) exp_overrun = 1'b1;
        step(0);
        bus.frame_tick = 1'b0;
        total++;
        if ({bus.busy, bus.ch_go, bus.plot, bus.timeout_flags, bus.overrun} !==
            {1'b0, 4'b0, 1'b0, exp_flags, exp_overrun}) begin
            bad++;
            $display("FAIL %s frame_end got=%b want=%b", tag,
                     {bus.busy, bus.ch_go, bus.plot, bus.timeout_flags, bus.overrun},
                     {1'b0, 4'b0, 1'b0, exp_flags, exp_overrun});
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(0);
        step(0);
        reset = 1'b0;
        clear_engines();
        exp_flags = '0;
        exp_overrun = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        step(0);
        total++;
        if ({bus.busy, bus.ch_go, bus.logic_go, bus.inc_enable, bus.erasing, bus.plot} !== 9'b0) begin
            bad++;
            $display("FAIL reset_ctrl got=%b want=%b",
                     {bus.busy, bus.ch_go, bus.logic_go, bus.inc_enable, bus.erasing, bus.plot}, 9'b0);
        end
        total++;
        if ({bus.timeout_flags, bus.overrun} !== 5'b0) begin
            bad++;
            $display("FAIL reset_status got=%b want=%b", {bus.timeout_flags, bus.overrun}, 5'b0);
        end
        step(1);
        total++;
        if ({bus.x, bus.y, bus.colour, bus.plot} !== {bus.load_x, bus.load_y, bus.load_colour, bus.load_we}) begin
            bad++;
            $display("FAIL reset_load_mux got=%h want=%h", {bus.x, bus.y, bus.colour, bus.plot},
                     {bus.load_x, bus.load_y, bus.load_colour, bus.load_we});
        end
        step(0);
    endtask

    task automatic test_go_order();
        noise = 1'b0;
        rand_pix = 1'b1;
        for (int i = 0; i < N; i++) dly[i] = 3;
        ldly = 3;
        run_frame(4'b1011, 4'b0001, -1, -1, 0, -1, "go_order");
    endtask

    task automatic test_erase_colour();
        logic [KW:0] got;
        rand_pix = 1'b0;
        noise = 1'b0;
        bus.ch_colour = 12'b000_000_000_111;
        bus.ch_we = 4'b0001;
        bus.ch_x = 40'd17;
        bus.ch_y = 40'd23;
        bus.ch_mask = 4'b0001;
        bus.erase_mask = 4'b0001;
        dly[0] = 1;
        ldly = 1;
        step(0);
        bus.frame_tick = 1'b1;
        step(0);
        bus.frame_tick = 1'b0;
        got = {bus.colour, bus.plot};
        total++;
        if (got !== 4'b0001) begin
            bad++;
            $display("FAIL erase_colour got=%b want=%b", got, 4'b0001);
        end
        for (int c = 0; c < 5; c++) step(0);
        got = {bus.colour, bus.plot};
        total++;
        if (got !== 4'b1111 || bus.ch_go !== 4'b0001) begin
            bad++;
            $display("FAIL draw_colour got=%b go=%b want=1111 go=0001", got, bus.ch_go);
        end
        step(0);
        step(0);
        total++;
        if (bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL min_frame_idle got=%b want=0", bus.busy);
        end
        rand_pix = 1'b1;
    endtask

    task automatic test_timeout();
        do_reset();
        dly[0] = 2; dly[1] = 16; dly[2] = 2; dly[3] = 2;
        ldly = 2;
        run_frame(4'b1111, 4'b0000, -1, -1, 0, -1, "done_on_timeout");
        dly[1] = 0;
        run_frame(4'b1111, 4'b0000, -1, -1, 0, -1, "timeout_ch1");
        total++;
        if (bus.timeout_flags !== 4'b0010) begin
            bad++;
            $display("FAIL timeout_flags got=%b want=%b", bus.timeout_flags, 4'b0010);
        end
    endtask

    task automatic test_overrun();
        for (int i = 0; i < N; i++) dly[i] = 2;
        ldly = 2;
        run_frame(4'b0110, 4'b0110, 4, -1, 0, -1, "overrun");
        total++;
        if (bus.overrun !== 1'b1) begin
            bad++;
            $display("FAIL overrun_sticky got=%b want=1", bus.overrun);
        end
    endtask

    task automatic test_load();
        bus.ch_mask = 4'b1111;
        bus.erase_mask = 4'b1111;
        step(1);
        bus.frame_tick = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step(1);
            bus.frame_tick = 1'b0;
            total++;
            if ({bus.busy, bus.ch_go, bus.x, bus.y, bus.colour, bus.plot} !==
                {1'b0, 4'b0, bus.load_x, bus.load_y, bus.load_colour, bus.load_we}) begin
                bad++;
                $display("FAIL load_idle cyc=%0d got=%h want=%h", c,
                         {bus.busy, bus.ch_go, bus.x, bus.y, bus.colour, bus.plot},
                         {1'b0, 4'b0, bus.load_x, bus.load_y, bus.load_colour, bus.load_we});
            end
        end
        step(0);
        total++;
        if (bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL load_tick_dropped got=%b want=0", bus.busy);
        end
        dly[0] = 0;
        ldly = 2;
        run_frame(4'b0001, 4'b0000, -1, 8, 5, -1, "load_freeze");
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < N; i++) dly[i] = 5;
        ldly = 2;
        run_frame(4'b1111, 4'b0000, -1, -1, 0, 7, "reset_mid");
    endtask

    task automatic test_random_frames();
        logic [N-1:0] m, e;
        int t, f;
        noise = 1'b1;
        rand_pix = 1'b1;
        for (int n = 0; n < 10; n++) begin
            m = 4'($urandom());
            e = 4'($urandom());
            for (int i = 0; i < N; i++) dly[i] = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 20);
            ldly = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 4);
            t = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 30) : -1;
            f = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 30) : -1;
            run_frame(m, e, t, f, $urandom_range(1, 4), -1, "random");
        end
        noise = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        bus.frame_tick = 1'b0;
        bus.ch_mask = '0;
        bus.erase_mask = '0;
        bus.ch_done = '0;
        bus.ch_x = '0;
        bus.ch_y = '0;
        bus.ch_colour = '0;
        bus.ch_we = '0;
        bus.load_active = 1'b0;
        bus.load_x = '0;
        bus.load_y = '0;
        bus.load_colour = '0;
        bus.load_we = 1'b0;
        bus.logic_done = 1'b0;
        noise = 1'b0;
        rand_pix = 1'b1;
        ldly = 1;
        for (int i = 0; i < N; i++) begin
            dly[i] = 1;
            cd[i] = 0;
        end
        lcd = 0;
        exp_flags = '0;
        exp_overrun = 1'b0;

        test_reset();
        test_go_order();
        test_erase_colour();
        test_timeout();
        test_overrun();
        test_load();
        test_reset_mid();
        test_random_frames();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1);
    end
endmodule
